// File: rtl/array_bubble_sort.sv
// In-place bubble-sort engine over a register array, early exit on a swap-free pass.
// Define SORT_SIGNED_EN for two's-complement element comparison (default unsigned).
module array_bubble_sort #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W:0]   length,
  input  logic              go,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       swaps
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COMPARE  = 3'd1;
  localparam logic [2:0] S_SWAP     = 3'd2;
  localparam logic [2:0] S_PASS_END = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] TWO_L   = (ADDR_W+1)'(2);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W:0]   limit_q, limit_d;
  logic              swapped_q, swapped_d;
  logic [15:0]       swaps_q, swaps_d;

  logic [ADDR_W-1:0] i_nxt;
  logic [WIDTH-1:0]  elem_a, elem_b;
  logic              a_gt_b;
  logic              last_pair;
  logic [ADDR_W:0]   len_clamp;

  assign i_nxt     = i_q + ADDR_W'(1);
  assign elem_a    = mem_q[i_q];
  assign elem_b    = mem_q[i_nxt];
  assign last_pair = (({1'b0, i_q} + TWO_L) == limit_q);
  assign len_clamp = (length > DEPTH_L) ? DEPTH_L : length;

`ifdef SORT_SIGNED_EN
  assign a_gt_b = $signed(elem_a) > $signed(elem_b);
`else
  assign a_gt_b = elem_a > elem_b;
`endif

  always_comb begin
    mem_d     = mem_q;
    state_d   = state_q;
    i_d       = i_q;
    limit_d   = limit_q;
    swapped_d = swapped_q;
    swaps_d   = swaps_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (wr_en) mem_d[wr_addr] = wr_data;
        if (go) begin
          limit_d   = len_clamp;
          i_d       = '0;
          swapped_d = 1'b0;
          swaps_d   = '0;
          state_d   = (len_clamp < TWO_L) ? S_DONE : S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (a_gt_b)         state_d = S_SWAP;
        else if (last_pair) state_d = S_PASS_END;
        else                i_d     = i_nxt;
      end
      S_SWAP: begin
        // Both words are rewritten on the same edge from the pre-swap values.
        mem_d[i_q]   = elem_b;
        mem_d[i_nxt] = elem_a;
        swapped_d    = 1'b1;
        if (swaps_q != '1) swaps_d = swaps_q + 16'd1;
        if (last_pair) begin
          state_d = S_PASS_END;
        end else begin
          i_d     = i_nxt;
          state_d = S_COMPARE;
        end
      end
      S_PASS_END: begin
        if (swapped_q && (limit_q > TWO_L)) begin
          limit_d   = limit_q - (ADDR_W+1)'(1);
          i_d       = '0;
          swapped_d = 1'b0;
          state_d   = S_COMPARE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      state_q   <= S_IDLE;
      i_q       <= '0;
      limit_q   <= '0;
      swapped_q <= 1'b0;
      swaps_q   <= '0;
    end else begin
      mem_q     <= mem_d;
      state_q   <= state_d;
      i_q       <= i_d;
      limit_q   <= limit_d;
      swapped_q <= swapped_d;
      swaps_q   <= swaps_d;
    end
  end

  assign rd_data = mem_q[rd_addr];
  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done    = (state_q == S_DONE);
  assign swaps   = swaps_q;

endmodule

// File: tb/tb_array_bubble_sort.sv
// Directed bench for array_bubble_sort with hand-computed expectations.
module tb_array_bubble_sort;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  length = '0;
  logic        go = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic [15:0] swaps;

  int checks = 0;
  int errors = 0;

  array_bubble_sort #(.WIDTH(32), .DEPTH(16), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .length(length), .go(go), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .swaps(swaps)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(posedge clock); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    rd_addr = addr; #1;
    check(tag, rd_data, exp);
  endtask

  // n = edges after the go-acceptance edge until done is seen
  task automatic run(input logic [4:0] len, input logic poke, output int n, output logic first_done);
    length = len; go = 1'b1;
    @(posedge clock); #1;
    go = 1'b0; n = 0;
    @(negedge clock);
    first_done = done;
    while (!done && n < 2000) begin
      check("busy_run", {31'd0, busy}, 32'd1);
      wr_en = poke; wr_addr = 4'd0; wr_data = 32'd99;
      @(posedge clock); n++;
      @(negedge clock);
    end
    wr_en = 1'b0;
    check("done_set", {31'd0, done}, 32'd1);
    check("busy_clr", {31'd0, busy}, 32'd0);
  endtask

  int   n;
  logic fd;

  initial begin
    // power-on reset
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_swaps", {16'd0, swaps}, 32'd0);
    reset = 1'b1;

    // reset asserted mid-run
    wr(4'd0, 32'd3); wr(4'd1, 32'd1); wr(4'd2, 32'd2);
    length = 5'd3; go = 1'b1;
    @(posedge clock); #1; go = 1'b0;
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    reset = 1'b0; #1;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_swaps", {16'd0, swaps}, 32'd0);
    for (int a = 0; a < 16; a++) rd_chk("mid_mem", 4'(a), 32'd0);
    @(negedge clock); reset = 1'b1;

    // unsorted [3,1,2]; index 3 holds 0 and must stay out of the sort
    wr(4'd0, 32'd3); wr(4'd1, 32'd1); wr(4'd2, 32'd2);
    run(5'd3, 1'b0, n, fd);
    check("uns_edges", n, 32'd7);
    check("uns_first", {31'd0, fd}, 32'd0);
    check("uns_swaps", {16'd0, swaps}, 32'd2);
    rd_chk("uns_m0", 4'd0, 32'd1);
    rd_chk("uns_m1", 4'd1, 32'd2);
    rd_chk("uns_m2", 4'd2, 32'd3);
    rd_chk("uns_m3", 4'd3, 32'd0);

    // sorted [1,2,3,4] with host writes attempted while busy
    wr(4'd0, 32'd1); wr(4'd1, 32'd2); wr(4'd2, 32'd3); wr(4'd3, 32'd4);
    run(5'd4, 1'b1, n, fd);
    check("srt_edges", n, 32'd4);
    check("srt_swaps", {16'd0, swaps}, 32'd0);
    for (int a = 0; a < 4; a++) rd_chk("srt_mem", 4'(a), 32'(a + 1));

    // restart from DONE: done must drop on the acceptance edge
    run(5'd4, 1'b0, n, fd);
    check("rst_first", {31'd0, fd}, 32'd0);
    check("rst_edges", n, 32'd4);

    // signedness on [0xFFFFFFFF, 5]
    wr(4'd0, 32'hFFFF_FFFF); wr(4'd1, 32'd5);
    run(5'd2, 1'b0, n, fd);
`ifdef SORT_SIGNED_EN
    check("sgn_swaps", {16'd0, swaps}, 32'd0);
    rd_chk("sgn_m0", 4'd0, 32'hFFFF_FFFF);
    rd_chk("sgn_m1", 4'd1, 32'd5);
`else
    check("sgn_swaps", {16'd0, swaps}, 32'd1);
    rd_chk("sgn_m0", 4'd0, 32'd5);
    rd_chk("sgn_m1", 4'd1, 32'hFFFF_FFFF);
`endif

    // boundary lengths 0 and 1
    run(5'd0, 1'b0, n, fd);
    check("len0_edges", n, 32'd0);
    check("len0_first", {31'd0, fd}, 32'd1);
    check("len0_swaps", {16'd0, swaps}, 32'd0);
    run(5'd1, 1'b0, n, fd);
    check("len1_edges", n, 32'd0);
    check("len1_swaps", {16'd0, swaps}, 32'd0);

    // reverse-sorted full array, length clamped from 20 to 16
    for (int a = 0; a < 16; a++) wr(4'(a), 32'(15 - a));
    run(5'd20, 1'b0, n, fd);
    check("rev_swaps", {16'd0, swaps}, 32'd120);
    for (int a = 0; a < 16; a++) rd_chk("rev_mem", 4'(a), 32'(a));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_bubble_sort.md
Name: array_bubble_sort

Overview:
- In-place bubble-sort engine for a small word array held in internal registers. It sits directly upstream of the array sort-check stage.
- Host loads the array through a write port, pulses go, and waits for done.
- The sort-check stage then reads the result through the combinational read port.
- Early exit: sorting stops on the first pass with no swaps.

Parameters:
WIDTH, 32, element width in bits
DEPTH, 16, array capacity in elements (power of 2, >= 2)
ADDR_W, 4, log2(DEPTH)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low (0 = reset asserted)
wr_en  input  1  write enable, honoured only when busy=0
wr_addr  input  ADDR_W  write index
wr_data  input  WIDTH  write data
length  input  ADDR_W+1  element count, sampled with go
go  input  1  start request
rd_addr  input  ADDR_W  read index
rd_data  output  WIDTH  mem[rd_addr], combinational
busy  output  1  high from go acceptance until DONE is entered
done  output  1  high while in DONE
swaps  output  16  swaps performed in the last run, saturating at 0xFFFF

Behaviour:
- Reset (asynchronous, while reset=0):
  - state=IDLE; all memory words=0; i=0; limit=0; swapped=0.
  - Outputs: swaps=0, busy=0, done=0.
- States: IDLE, COMPARE, SWAP, PASS_END, DONE. One state per cycle; no multi-cycle states.
- IDLE / DONE:
  - wr_en=1 writes mem[wr_addr]=wr_data at the clock edge.
  - go=1 loads limit=min(length,DEPTH), clears i, swapped and swaps.
  - If limit<2, the next state is DONE; otherwise COMPARE.
  - go accepted in DONE restarts the engine; done drops on that edge.
  - If go and wr_en are both high in IDLE or DONE, the write is performed and the run starts on the same edge.
- COMPARE:
  - Compare mem[i] and mem[i+1]. If mem[i] > mem[i+1], next state is SWAP.
  - Otherwise advance: if i+2==limit, go to PASS_END; else i++ and stay in COMPARE.
- SWAP:
  - Exchange mem[i] and mem[i+1] in one edge (two internal write paths).
  - Set swapped=1; swaps++ (saturating).
  - Then advance using the same rule as COMPARE.
- PASS_END:
  - If swapped=1 and limit>2: limit--, i=0, swapped=0, go to COMPARE.
  - Otherwise go to DONE.
- DONE: done=1, busy=0. Held until go is accepted or reset.
- While busy=1:
  - wr_en is ignored and the memory is written only by the engine.
  - go is ignored.
- Equal elements are never swapped, so the sort is stable.
- length > DEPTH is clamped to DEPTH. Words at index >= limit are never touched.
- Reset mid-run aborts immediately: memory is cleared and the engine returns to IDLE with no partial result retained.
- rd_data is always live and reflects in-progress swaps while busy.

Optional Feature:
- Macro: SORT_SIGNED_EN.
- Defined: element comparison is two's-complement signed.
- Undefined: element comparison is unsigned.
- Nothing else changes: same states, timing and ports.

Test Plan:
- Reset: drive reset=0 mid-run on array [3,1,2] -> busy=0, done=0, swaps=0, rd_data=0 for every address, state IDLE; the next go runs normally.
- Unsorted input: write [3,1,2], length=3, go sampled at edge E0.
  - Required sequence: C,S,C,S,PE,C,PE; done=1 after edge E7.
  - Result: swaps=2, mem=[1,2,3]; busy high from E0 up to E7.
- Sorted input: write [1,2,3,4], length=4, go.
  - done after edge E4; swaps=0; memory unchanged; writes attempted at E1-E3 are ignored.
- Boundary lengths:
  - length=0 and length=1 -> done one edge after go, swaps=0.
  - length=20 with a DEPTH=16 reverse-sorted array [15..0] -> sorted 0..15, swaps=120.
  - Re-issue go while in DONE -> restarts; done drops at the acceptance edge.
- Signedness: write [0xFFFFFFFF,5], length=2, go.
  - SORT_SIGNED_EN undefined -> result [5,0xFFFFFFFF], swaps=1.
  - SORT_SIGNED_EN defined -> unchanged, swaps=0.
